// File: rtl/i2c_arb_pkg.sv
// Shared constants for the I2C bus arbiter: state encoding, default timing
// and the ID-width helper used to size owner/requester indices.
package i2c_arb_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GUARD = 2'd2;

    localparam logic [15:0] GUARD_CYCLES_DFLT   = 16'd250;
    localparam logic [31:0] TIMEOUT_CYCLES_DFLT = 32'd5000000;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from
// the slot after the last owner, wrapping at NUM_REQ.
module rr_pick
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic               valid_o,
    output logic [ID_W-1:0]    pick_o
);

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % NUM_REQ;
        return ID_W'(s);
    endfunction

    // Walk offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        valid_o = |req_i;
        pick_o  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (req_i[wrap_idx(last_i, i)]) pick_o = wrap_idx(last_i, i);
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner of the shared I2C bus with a post-release guard gap and a
// watchdog that forcibly releases a master holding the bus too long.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int          NUM_REQ        = 3,
    parameter logic [15:0] GUARD_CYCLES   = GUARD_CYCLES_DFLT,
    parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DFLT,
    parameter int          ID_W           = id_width(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] done_i,
    input  logic [NUM_REQ-1:0] scl_oe_in_i,
    input  logic [NUM_REQ-1:0] sda_oe_in_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               scl_oe_o,
    output logic               sda_oe_o,
    output logic               busy_o,
    output logic [ID_W-1:0]    owner_id_o,
    output logic               timeout_err_o,
    output logic [ID_W-1:0]    timeout_id_o,
    input  logic               timeout_clr_i
);

    logic [1:0]         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               scl_q, scl_d, sda_q, sda_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic               err_q, err_d;
    logic [ID_W-1:0]    tid_q, tid_d;
    logic [31:0]        tmo_cnt_q, tmo_cnt_d;
    logic [15:0]        gap_cnt_q, gap_cnt_d;

    logic               pick_valid;
    logic [ID_W-1:0]    pick_idx;
    logic               tmo_hit, gap_done;

    rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
        .req_i   (req_i),
        .last_i  (owner_q),
        .valid_o (pick_valid),
        .pick_o  (pick_idx)
    );

    // Compare count+1 against the limit so a limit of 0 cannot underflow.
    assign tmo_hit  = ({1'b0, tmo_cnt_q} + 33'd1) >= {1'b0, TIMEOUT_CYCLES};
    assign gap_done = ({1'b0, gap_cnt_q} + 17'd1) >= {1'b0, GUARD_CYCLES};

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        scl_d     = 1'b0;
        sda_d     = 1'b0;
        owner_d   = owner_q;
        err_d     = timeout_clr_i ? 1'b0 : err_q;
        tid_d     = tid_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    tmo_cnt_d         = '0;
                    state_d           = S_GRANT;
                end
            end
            S_GRANT: begin
                scl_d = scl_oe_in_i[owner_q];
                sda_d = sda_oe_in_i[owner_q];
                if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (tmo_hit || done_i[owner_q] || !req_i[owner_q]) begin
                    if (tmo_hit) begin
                        err_d = 1'b1;
                        tid_d = owner_q;
                    end
                    grant_d   = '0;
                    scl_d     = 1'b0;
                    sda_d     = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = S_GUARD;
                end
            end
            S_GUARD: begin
                grant_d   = '0;
                gap_cnt_d = gap_cnt_q + 16'd1;
                if (gap_done) state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            scl_q     <= 1'b0;
            sda_q     <= 1'b0;
            owner_q   <= ID_W'(NUM_REQ - 1);
            err_q     <= 1'b0;
            tid_q     <= '0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            owner_q   <= owner_d;
            err_q     <= err_d;
            tid_q     <= tid_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign grant_o       = grant_q;
    assign scl_oe_o      = scl_q;
    assign sda_oe_o      = sda_q;
    assign busy_o        = (state_q == S_GRANT) || (state_q == S_GUARD);
    assign owner_id_o    = owner_q;
    assign timeout_err_o = err_q;
    assign timeout_id_o  = tid_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed bench for i2c_bus_arbiter; grant transitions are checked against a
// queue of expected (grant, cycle) events by an independent monitor.
module tb_i2c_bus_arbiter;

    localparam int N = 3;
    localparam int G = 8;
    localparam int T = 100;

    logic         clk = 1'b0;
    logic         reset_i;
    logic [N-1:0] req_i, done_i, scl_oe_in_i, sda_oe_in_i;
    logic [N-1:0] grant_o;
    logic         scl_oe_o, sda_oe_o, busy_o, timeout_err_o, timeout_clr_i;
    logic [1:0]   owner_id_o, timeout_id_o;

    always #5 clk = ~clk;

    i2c_bus_arbiter #(
        .NUM_REQ(N), .GUARD_CYCLES(16'(G)), .TIMEOUT_CYCLES(32'(T)), .ID_W(2)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .req_i         (req_i),
        .done_i        (done_i),
        .scl_oe_in_i   (scl_oe_in_i),
        .sda_oe_in_i   (sda_oe_in_i),
        .grant_o       (grant_o),
        .scl_oe_o      (scl_oe_o),
        .sda_oe_o      (sda_oe_o),
        .busy_o        (busy_o),
        .owner_id_o    (owner_id_o),
        .timeout_err_o (timeout_err_o),
        .timeout_id_o  (timeout_id_o),
        .timeout_clr_i (timeout_clr_i)
    );

    typedef struct { logic [N-1:0] g; int c; } ev_t;
    ev_t exp_q[$];
    ev_t mon_e;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    logic [N-1:0] prev_g = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_g(input logic [N-1:0] g, input int c);
        exp_q.push_back('{g, c});
    endtask

    task automatic pulse_done(input int id, input int at);
        goto(at);
        done_i[id] = 1'b1;
        goto(at + 1);
        done_i = '0;
    endtask

    // Monitor: invariants every cycle, grant edges against the scoreboard.
    always @(negedge clk) begin
        if (cyc >= 2) begin
            chk("grant_onehot", 32'($countones(grant_o) <= 1), 32'd1);
            if (grant_o == '0) begin
                chk("scl_released", 32'(scl_oe_o), 32'd0);
                chk("sda_released", 32'(sda_oe_o), 32'd0);
            end
            if (grant_o !== prev_g) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL grant_unexpected at cycle %0d: got %0b expected no change", cyc, grant_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("grant_value", 32'(grant_o), 32'(mon_e.g));
                    chk("grant_cycle", 32'(cyc), 32'(mon_e.c));
                end
                prev_g = grant_o;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [9:0] sp;
        logic [9:0] dp;
        int g;
        sp = 10'b1011001101;
        dp = 10'b0110100110;
        reset_i = 1'b1;
        req_i = '0;
        done_i = '0;
        scl_oe_in_i = '0;
        sda_oe_in_i = '0;
        timeout_clr_i = 1'b0;

        goto(3);
        reset_i = 1'b0;
        chk("rst_grant", 32'(grant_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_owner", 32'(owner_id_o), 32'd2);
        chk("rst_terr", 32'(timeout_err_o), 32'd0);
        chk("rst_tid", 32'(timeout_id_o), 32'd0);

        // Round-robin with all three requesting: order 0,1,2,0, gap G+1.
        goto(10);
        req_i = 3'b111;
        g = 11;
        for (int k = 0; k < 4; k++) begin
            expect_g(3'(1 << (k % 3)), g);
            expect_g(3'b000, g + 21);
            pulse_done(k % 3, g + 20);
            g = g + 30;
        end
        req_i = '0;

        // Bus mux follows owner 2 with one cycle of lag; non-owners drive 1.
        goto(140);
        req_i = 3'b100;
        scl_oe_in_i = 3'b011;
        sda_oe_in_i = 3'b011;
        expect_g(3'b100, 141);
        expect_g(3'b000, 152);
        for (int i = 0; i < 10; i++) begin
            goto(141 + i);
            if (i > 0) begin
                chk("scl_mux", 32'(scl_oe_o), 32'(sp[i-1]));
                chk("sda_mux", 32'(sda_oe_o), 32'(dp[i-1]));
            end
            scl_oe_in_i[2] = sp[i];
            sda_oe_in_i[2] = dp[i];
        end
        goto(151);
        chk("scl_mux_last", 32'(scl_oe_o), 32'(sp[9]));
        chk("sda_mux_last", 32'(sda_oe_o), 32'(dp[9]));
        scl_oe_in_i = 3'b111;
        sda_oe_in_i = 3'b111;
        pulse_done(2, 151);
        req_i = '0;
        goto(155);
        chk("scl_guard", 32'(scl_oe_o), 32'd0);
        chk("sda_guard", 32'(sda_oe_o), 32'd0);
        chk("busy_guard", 32'(busy_o), 32'd1);
        scl_oe_in_i = '0;
        sda_oe_in_i = '0;

        // Stray done from a non-owner, abandon by owner 1, pending 2 wins.
        goto(170);
        req_i = 3'b010;
        expect_g(3'b010, 171);
        expect_g(3'b000, 191);
        expect_g(3'b100, 200);
        expect_g(3'b000, 211);
        pulse_done(2, 180);
        goto(185);
        req_i = 3'b110;
        goto(190);
        req_i = 3'b100;
        pulse_done(1, 195);
        goto(200);
        chk("owner_after_abandon", 32'(owner_id_o), 32'd2);
        pulse_done(2, 210);
        req_i = '0;

        // Timeout with done on the terminal cycle still flags the error.
        goto(230);
        req_i = 3'b001;
        expect_g(3'b001, 231);
        expect_g(3'b000, 331);
        goto(330);
        chk("terr_before", 32'(timeout_err_o), 32'd0);
        done_i[0] = 1'b1;
        goto(331);
        done_i = '0;
        req_i = '0;
        chk("terr_set", 32'(timeout_err_o), 32'd1);
        chk("tid_0", 32'(timeout_id_o), 32'd0);
        chk("busy_after_tmo", 32'(busy_o), 32'd1);
        goto(335);
        timeout_clr_i = 1'b1;
        goto(336);
        timeout_clr_i = 1'b0;
        chk("terr_cleared", 32'(timeout_err_o), 32'd0);

        // Second timeout by requester 1 with clear on the same edge: set wins.
        goto(345);
        req_i = 3'b010;
        expect_g(3'b010, 346);
        expect_g(3'b000, 446);
        goto(445);
        timeout_clr_i = 1'b1;
        goto(446);
        timeout_clr_i = 1'b0;
        req_i = '0;
        chk("terr_set_wins", 32'(timeout_err_o), 32'd1);
        chk("tid_1", 32'(timeout_id_o), 32'd1);

        // Reset while requester 0 owns the bus.
        goto(460);
        req_i = 3'b001;
        scl_oe_in_i = 3'b001;
        expect_g(3'b001, 461);
        goto(465);
        chk("scl_owner0", 32'(scl_oe_o), 32'd1);
        goto(470);
        reset_i = 1'b1;
        req_i = 3'b011;
        expect_g(3'b000, 471);
        expect_g(3'b001, 472);
        goto(471);
        reset_i = 1'b0;
        scl_oe_in_i = '0;
        chk("midrst_grant", 32'(grant_o), 32'd0);
        chk("midrst_scl", 32'(scl_oe_o), 32'd0);
        chk("midrst_owner", 32'(owner_id_o), 32'd2);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_terr", 32'(timeout_err_o), 32'd0);
        chk("midrst_tid", 32'(timeout_id_o), 32'd0);
        expect_g(3'b000, 481);
        expect_g(3'b010, 490);
        expect_g(3'b000, 496);
        pulse_done(0, 480);
        req_i = 3'b010;
        pulse_done(1, 495);
        req_i = '0;

        goto(520);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
